// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window sequencer: the FSM state
// encoding, default datapath widths and the output-grid dimension helper.
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int K_DEF      = 3;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;

    // Number of valid (unpadded) window positions along one image axis.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer_if
// Groups the buffer read bus and the result stream of the sequencer.
//   rd_en / pix_addr / wgt_addr   : read request to pixel and weight buffers
//   pix_data / wgt_data           : signed read data, valid 1 cycle after rd_en
//   out_pix / out_row / out_col   : window sum and its output-grid position
//   out_valid / out_ready         : result handshake
// master = sequencer side, slave = buffers plus downstream consumer.
// ---------------------------------------------------------------------------
interface conv_window_sequencer_if #(
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20
);
    logic                      rd_en;
    logic [ADDR_W-1:0]         pix_addr;
    logic [WADDR_W-1:0]        wgt_addr;
    logic signed [DATA_W-1:0]  pix_data;
    logic signed [DATA_W-1:0]  wgt_data;
    logic signed [ACC_W-1:0]   out_pix;
    logic [15:0]               out_row;
    logic [15:0]               out_col;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output rd_en, pix_addr, wgt_addr,
        input  pix_data, wgt_data,
        output out_pix, out_row, out_col, out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_en, pix_addr, wgt_addr,
        output pix_data, wgt_data,
        input  out_pix, out_row, out_col, out_valid,
        output out_ready
    );
endinterface

// File: rtl/conv_window_sequencer_mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
// Signed DATA_W x DATA_W multiply feeding a registered accumulator.
//   clk, rst : clock, asynchronous active-high reset (acc cleared)
//   en       : accumulate this cycle's product
//   first    : replace instead of add (starts a new window sum)
//   a, b     : signed operands
//   acc      : signed running sum, updated one cycle after en
// ---------------------------------------------------------------------------
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    product_ext;

    assign product     = a * b;
    // Size cast of a signed value sign-extends; the full product is kept.
    assign product_ext = ACC_W'(product);

    // Replacing on the first tap clears the previous window's sum for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= first ? product_ext : acc + product_ext;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
// Walks the valid KxK windows of an IMG_W x IMG_H tile in raster order,
// reads K*K pixel/weight pairs per window, accumulates their products and
// hands each window sum downstream over a valid/ready stream.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a full-image pass (only honoured in IDLE)
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse after the final output handshake
//   bus      : read bus + result stream (master modport)
// ---------------------------------------------------------------------------
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = K_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv_window_sequencer_if.master bus
);

    localparam int OH = out_dim(IMG_H, K);
    localparam int OW = out_dim(IMG_W, K);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [WADDR_W-1:0] LAST_TAP = WADDR_W'(K * K - 1);
    localparam logic [KW-1:0]      LAST_K   = KW'(K - 1);
    localparam logic [15:0]        LAST_ROW = 16'(OH - 1);
    localparam logic [15:0]        LAST_COL = 16'(OW - 1);

    // A kernel larger than the image has no valid window position.
    if (K > IMG_W || K > IMG_H) begin : g_bad_params
        $error("conv_window_sequencer: K must not exceed IMG_W or IMG_H");
    end

    state_t state, state_next;

    logic [WADDR_W-1:0]       tap;
    logic [KW-1:0]            kr;
    logic [KW-1:0]            kc;
    logic [15:0]              row;
    logic [15:0]              col;
    logic                     mac_en;
    logic                     mac_first;
    logic                     last_tap;
    logic                     last_win;
    logic                     handshake;
    logic signed [ACC_W-1:0]  acc;

    assign last_tap  = (tap == LAST_TAP);
    assign last_win  = (row == LAST_ROW) && (col == LAST_COL);
    assign handshake = (state == ST_OUTPUT) && bus.out_ready;

    // kr/kc track tap/K and tap%K incrementally so no divider is needed.
    assign bus.pix_addr = ADDR_W'((ADDR_W'(row) + ADDR_W'(kr)) * ADDR_W'(IMG_W)
                                  + ADDR_W'(col) + ADDR_W'(kc));
    assign bus.wgt_addr = tap;
    assign bus.out_pix  = acc;
    assign bus.out_row  = row;
    assign bus.out_col  = col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy          = 1'b1;
        done          = 1'b0;
        bus.rd_en     = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                bus.rd_en = 1'b1;
                if (last_tap) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = last_win ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Tap and window counters. Row/col only move on a handshake, which is
    // what keeps out_row/out_col stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap <= '0;
            kr  <= '0;
            kc  <= '0;
            row <= '0;
            col <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tap <= '0;
                        kr  <= '0;
                        kc  <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end
                ST_FETCH: begin
                    if (last_tap) begin
                        tap <= '0;
                        kr  <= '0;
                        kc  <= '0;
                    end else begin
                        tap <= tap + WADDR_W'(1);
                        if (kc == LAST_K) begin
                            kc <= '0;
                            kr <= kr + KW'(1);
                        end else begin
                            kc <= kc + KW'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (handshake && !last_win) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 16'd1;
                        end else begin
                            col <= col + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer data arrives one cycle after rd_en, so the MAC controls are
    // the read strobe and first-tap flag delayed by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_en    <= (state == ST_FETCH);
            mac_first <= (state == ST_FETCH) && (tap == '0);
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .first (mac_first),
        .a     (bus.pix_data),
        .b     (bus.wgt_data),
        .acc   (acc)
    );

endmodule

// File: tb/tb_conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_sequencer
// Self-checking bench for conv_window_sequencer on a 5x4 tile with K=3
// (2x3 output grid). Window sums are recomputed from the stored tile with
// plain nested loops and compared against every accepted output.
// ---------------------------------------------------------------------------
module tb_conv_window_sequencer;

    localparam int IMG_W   = 5;
    localparam int IMG_H   = 4;
    localparam int K       = 3;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 20;
    localparam int ADDR_W  = 10;
    localparam int WADDR_W = 4;
    localparam int OH      = IMG_H - K + 1;
    localparam int OW      = IMG_W - K + 1;
    localparam int NWIN    = OH * OW;
    localparam int NTAP    = K * K;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    conv_window_sequencer_if #(
        .ADDR_W(ADDR_W), .WADDR_W(WADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)
    ) bus ();

    conv_window_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DATA_W(DATA_W),
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Buffer contents and the registered-read buffer model.
    logic signed [DATA_W-1:0] pix_mem [IMG_W*IMG_H];
    logic signed [DATA_W-1:0] wgt_mem [NTAP];

    logic               rd_s = 1'b0;
    logic [ADDR_W-1:0]  pa_s = '0;
    logic [WADDR_W-1:0] wa_s = '0;

    always @(negedge clk) begin
        rd_s = bus.rd_en;
        pa_s = bus.pix_addr;
        wa_s = bus.wgt_addr;
    end

    always @(posedge clk) begin
        if (rd_s) begin
            bus.pix_data <= pix_mem[pa_s];
            bus.wgt_data <= wgt_mem[wa_s];
        end
    end

    // Scoreboard capture, sampled mid-cycle.
    typedef struct { int row; int col; longint pix; } hs_t;
    typedef struct { int pa; int wa; } rd_t;

    hs_t hs_q[$];
    rd_t trace_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_hs_cyc = 0;
    int  overlap_cnt = 0;
    int  errors = 0;
    int  checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                hs_q.push_back('{row: int'(bus.out_row), col: int'(bus.out_col),
                                 pix: longint'(bus.out_pix)});
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.rd_en) begin
                trace_q.push_back('{pa: int'(bus.pix_addr), wa: int'(bus.wgt_addr)});
            end
            if (bus.out_valid && bus.rd_en) begin
                overlap_cnt++;
            end
        end
    end

    // Reference: a window sum straight from the tile and kernel contents.
    function automatic longint winSum(input int r, input int c);
        longint s = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                s += longint'(pix_mem[(r + i) * IMG_W + c + j]) * longint'(wgt_mem[i * K + j]);
            end
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start         = s;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic fillMem(input bit rnd, input int pv, input int wv);
        for (int i = 0; i < IMG_W * IMG_H; i++)
            pix_mem[i] = rnd ? DATA_W'($urandom) : DATA_W'(pv);
        for (int i = 0; i < NTAP; i++)
            wgt_mem[i] = rnd ? DATA_W'($urandom) : DATA_W'(wv);
    endtask

    task automatic clearScoreboard();
        hs_q.delete();
        trace_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
    endtask

    task automatic waitPass(input bit rnd_ready, input bit mid_start);
        int  n = 0;
        bit  pulsed = 0;
        logic st;
        while (done_cnt == 0 && n < 3000) begin
            st = 1'b0;
            if (mid_start && !pulsed && hs_q.size() == 1 && bus.rd_en && bus.wgt_addr == 2) begin
                st     = 1'b1;
                pulsed = 1;
            end
            applyStimulus(st, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pass_timeout: got no done expected done within 3000 cycles");
        end
        if (mid_start) checkOutput("mid_start_pulsed", 64'(pulsed), 1);
        repeat (4) applyStimulus(1'b0, 1'b1);
    endtask

    task automatic checkPass(input string tag);
        checkOutput({tag, "_count"}, hs_q.size(), NWIN);
        for (int w = 0; w < NWIN && w < hs_q.size(); w++) begin
            checkOutput($sformatf("%s_w%0d_row", tag, w), hs_q[w].row, w / OW);
            checkOutput($sformatf("%s_w%0d_col", tag, w), hs_q[w].col, w % OW);
            checkOutput($sformatf("%s_w%0d_pix", tag, w), hs_q[w].pix, winSum(w / OW, w % OW));
        end
        checkOutput({tag, "_done_cnt"}, done_cnt, 1);
        checkOutput({tag, "_done_delay"}, done_cyc - last_hs_cyc, 1);
        checkOutput({tag, "_rd_in_output"}, overlap_cnt, 0);
    endtask

    typedef struct {
        logic start;
        logic ready;
        logic busy;
        logic rd;
        logic ov;
        logic dn;
        int   wa;
    } vec_t;

    vec_t vecs [11];
    int   exp_pa [NTAP];

    initial begin
        // Cycle-by-cycle view of the first window from start to out_valid.
        for (int i = 0; i < 11; i++) begin
            vecs[i].start = (i == 0);
            vecs[i].ready = 1'b0;
            vecs[i].busy  = 1'b1;
            vecs[i].rd    = (i < 9);
            vecs[i].ov    = (i == 10);
            vecs[i].dn    = 1'b0;
            vecs[i].wa    = (i < 9) ? i : 0;
        end
        exp_pa = '{7, 8, 9, 12, 13, 14, 17, 18, 19};

        rst           = 1'b1;
        start         = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_en", bus.rd_en, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_pix_addr", bus.pix_addr, 0);
        checkOutput("rst_wgt_addr", bus.wgt_addr, 0);
        checkOutput("rst_out_pix", $signed(bus.out_pix), 0);
        checkOutput("rst_out_row", bus.out_row, 0);
        checkOutput("rst_out_col", bus.out_col, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("idle_no_start_busy", busy, 0);

        // All-ones tile: table-driven latency, then backpressure by hand.
        fillMem(1'b0, 1, 1);
        clearScoreboard();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].start, vecs[i].ready);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            checkOutput($sformatf("vec%0d_rd_en", i), bus.rd_en, vecs[i].rd);
            checkOutput($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].ov);
            checkOutput($sformatf("vec%0d_done", i), done, vecs[i].dn);
            checkOutput($sformatf("vec%0d_wgt_addr", i), bus.wgt_addr, vecs[i].wa);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("bp%0d_out_valid", i), bus.out_valid, 1);
            checkOutput($sformatf("bp%0d_out_pix", i), $signed(bus.out_pix), 9);
            checkOutput($sformatf("bp%0d_out_row", i), bus.out_row, 0);
            checkOutput($sformatf("bp%0d_out_col", i), bus.out_col, 0);
            checkOutput($sformatf("bp%0d_rd_en", i), bus.rd_en, 0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("post_hs_out_valid", bus.out_valid, 0);
        checkOutput("post_hs_rd_en", bus.rd_en, 1);
        checkOutput("post_hs_pix_addr", bus.pix_addr, 1);
        checkOutput("post_hs_wgt_addr", bus.wgt_addr, 0);
        waitPass(1'b0, 1'b0);
        checkPass("ones");
        checkOutput("ones_first_pix", hs_q.size() > 0 ? hs_q[0].pix : -1, 9);
        checkOutput("trace_len", trace_q.size(), NWIN * NTAP);
        for (int k = 0; k < NTAP; k++) begin
            if (5 * NTAP + k < trace_q.size()) begin
                checkOutput($sformatf("trace_pa%0d", k), trace_q[5 * NTAP + k].pa, exp_pa[k]);
                checkOutput($sformatf("trace_wa%0d", k), trace_q[5 * NTAP + k].wa, k);
            end
        end

        // Sign and width extremes.
        fillMem(1'b0, -128, -128);
        clearScoreboard();
        applyStimulus(1'b1, 1'b1);
        waitPass(1'b0, 1'b0);
        checkPass("negneg");
        checkOutput("negneg_pix", hs_q.size() > 0 ? hs_q[0].pix : 0, 147456);

        fillMem(1'b0, 127, -128);
        clearScoreboard();
        applyStimulus(1'b1, 1'b1);
        waitPass(1'b0, 1'b0);
        checkPass("posneg");
        checkOutput("posneg_pix", hs_q.size() > 0 ? hs_q[0].pix : 0, -146304);

        // Reset in the middle of FETCH, at tap 4.
        fillMem(1'b1, 0, 0);
        clearScoreboard();
        applyStimulus(1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1);
        checkOutput("pre_rst_wgt_addr", bus.wgt_addr, 4);
        checkOutput("pre_rst_rd_en", bus.rd_en, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rd_en", bus.rd_en, 0);
        checkOutput("mid_rst_out_valid", bus.out_valid, 0);
        checkOutput("mid_rst_wgt_addr", bus.wgt_addr, 0);
        checkOutput("mid_rst_out_pix", $signed(bus.out_pix), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b1);
        checkOutput("mid_rst_no_done", done_cnt, 0);
        checkOutput("mid_rst_no_output", hs_q.size(), 0);
        fillMem(1'b1, 0, 0);
        clearScoreboard();
        applyStimulus(1'b1, 1'b1);
        waitPass(1'b0, 1'b0);
        checkPass("after_rst");

        // Randomized tiles with random backpressure; one pass gets a stray start.
        for (int p = 0; p < 3; p++) begin
            fillMem(1'b1, 0, 0);
            clearScoreboard();
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            waitPass(1'b1, p == 1);
            checkPass($sformatf("rand%0d", p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
